// File: rtl/usb_transaction_sequencer_pkg.sv
// Shared PID encodings, state type, handshake/data PID bytes and the USB CRC16
// per-byte update used by the IN payload CRC generator.
package usb_transaction_sequencer_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_RX_DATA   = 3'd2,
    S_SEND_HS   = 3'd3,
    S_SEND_PID  = 3'd4,
    S_SEND_DATA = 3'd5,
    S_SEND_CRC  = 3'd6,
    S_WAIT_HS   = 3'd7
  } state_t;

  localparam logic [7:0]  BYTE_ACK   = 8'hD2;
  localparam logic [7:0]  BYTE_NAK   = 8'h5A;
  localparam logic [7:0]  BYTE_STALL = 8'h1E;
  localparam logic [7:0]  BYTE_DATA0 = 8'hC3;
  localparam logic [7:0]  BYTE_DATA1 = 8'h4B;
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Reflected x^16+x^15+x^2+1, LSB-first, one byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_transaction_sequencer_crc16_gen.sv
// Running USB CRC16 over IN payload bytes; crc_o is the complemented remainder
// ready to transmit low byte first.
module usb_crc16_gen
  import usb_transaction_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        data_valid_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  // Next remainder: restart, absorb a byte, or hold.
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC16_INIT;
    end else if (data_valid_i) begin
      crc_d = crc16_byte(crc_q, data_i);
    end else begin
      crc_d = crc_q;
    end
  end

  // Remainder register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = ~crc_q;

endmodule

// File: rtl/usb_transaction_sequencer.sv
// USB full-speed transaction sequencer: token filtering, per-endpoint DATA0/1
// toggles, handshake and IN data packet generation towards the SIE.
module usb_transaction_sequencer
  import usb_transaction_sequencer_pkg::*;
#(
  parameter int NUM_EP  = 2,
  parameter int MAX_PKT = 8,
  parameter int TIMEOUT = 40
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [6:0]        dev_addr_i,
  input  logic [3:0]        pid_i,
  input  logic              pid_valid_i,
  input  logic [6:0]        address_i,
  input  logic [3:0]        end_point_i,
  input  logic              token_valid_i,
  input  logic              rx_active_i,
  input  logic              crc16_ok_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [NUM_EP-1:0] ep_stall_i,
  input  logic [NUM_EP-1:0] out_ready_i,
  output logic              out_commit_o,
  output logic              out_setup_o,
  input  logic [NUM_EP-1:0] in_avail_i,
  input  logic [6:0]        in_len_i,
  input  logic [7:0]        in_data_i,
  output logic              in_rd_o,
  output logic              in_done_o,
  output logic [3:0]        xfer_ep_o
);

  localparam int              EPW      = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      NUM_EP_W = 5'(NUM_EP);
  localparam logic [6:0]      MAX_LEN  = 7'(MAX_PKT);
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [3:0]        tok_pid_q, tok_pid_d;
  logic [3:0]        ep_q, ep_d;
  logic [6:0]        len_q, len_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              data1_q, data1_d;
  logic              crc_hi_q, crc_hi_d;
  logic [NUM_EP-1:0] out_tog_q, out_tog_d;
  logic [NUM_EP-1:0] in_tog_q, in_tog_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              out_commit_q, out_commit_d;
  logic              out_setup_q, out_setup_d;
  logic              in_done_q, in_done_d;

  logic [3:0]     tok_pid_s;
  logic           tok_hit_s;
  logic           byte_done_s;
  logic           in_rd_s;
  logic [EPW-1:0] ep_idx_s;
  logic [EPW-1:0] tok_idx_s;
  logic [15:0]    crc_s;

  // The token PID may arrive together with the token strobe or just before it.
  assign tok_pid_s   = pid_valid_i ? pid_i : tok_pid_q;
  assign tok_hit_s   = token_valid_i && (address_i == dev_addr_i) &&
                       ({1'b0, end_point_i} < NUM_EP_W) &&
                       ((tok_pid_s == PID_OUT) || (tok_pid_s == PID_IN) || (tok_pid_s == PID_SETUP));
  assign byte_done_s = tx_valid_q && tx_ready_i;
  assign in_rd_s     = (state_q == S_SEND_DATA) && byte_done_s && !reset_i;
  assign ep_idx_s    = ep_q[EPW-1:0];
  assign tok_idx_s   = end_point_i[EPW-1:0];

  usb_crc16_gen u_crc (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (state_q == S_SEND_PID),
    .data_valid_i (in_rd_s),
    .data_i       (in_data_i),
    .crc_o        (crc_s)
  );

  // Transaction FSM next state, toggles and TX byte sequencing.
  always_comb begin
    state_d      = state_q;
    tok_pid_d    = tok_pid_q;
    ep_d         = ep_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    tmr_d        = {TW{1'b0}};
    data1_d      = data1_q;
    crc_hi_d     = crc_hi_q;
    out_tog_d    = out_tog_q;
    in_tog_d     = in_tog_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    out_commit_d = 1'b0;
    out_setup_d  = 1'b0;
    in_done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pid_valid_i) begin
          tok_pid_d = pid_i;
        end else begin
          tok_pid_d = tok_pid_q;
        end
        if (tok_hit_s) begin
          ep_d = end_point_i;
          if (tok_pid_s == PID_IN) begin
            len_d    = (in_len_i > MAX_LEN) ? MAX_LEN : in_len_i;
            cnt_d    = 7'd0;
            crc_hi_d = 1'b0;
            if (ep_stall_i[tok_idx_s]) begin
              state_d   = S_SEND_HS;
              tx_data_d = BYTE_STALL;
            end else if (!in_avail_i[tok_idx_s]) begin
              state_d   = S_SEND_HS;
              tx_data_d = BYTE_NAK;
            end else begin
              state_d = S_SEND_PID;
            end
          end else begin
            state_d = S_WAIT_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        if (pid_valid_i) begin
          if ((pid_i == PID_DATA0) || (pid_i == PID_DATA1)) begin
            state_d = S_RX_DATA;
            data1_d = pid_i[3];
          end else begin
            state_d = S_IDLE;
          end
        end else if (tmr_q == T_LAST) begin
          state_d = S_IDLE;
        end else if (rx_active_i) begin
          tmr_d = tmr_q;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_RX_DATA: begin
        if (rx_active_i) begin
          state_d = S_RX_DATA;
        end else if (!crc16_ok_i) begin
          state_d = S_IDLE;
        end else begin
          // Handshake is loaded here so tx_valid rises on the very next cycle.
          state_d    = S_SEND_HS;
          tx_valid_d = 1'b1;
          if (tok_pid_q == PID_SETUP) begin
            tx_data_d            = BYTE_ACK;
            out_commit_d         = 1'b1;
            out_setup_d          = 1'b1;
            out_tog_d[ep_idx_s]  = 1'b1;
            in_tog_d[ep_idx_s]   = 1'b1;
          end else if (ep_stall_i[ep_idx_s]) begin
            tx_data_d = BYTE_STALL;
          end else if (!out_ready_i[ep_idx_s]) begin
            tx_data_d = BYTE_NAK;
          end else if (data1_q != out_tog_q[ep_idx_s]) begin
            tx_data_d = BYTE_ACK;
          end else begin
            tx_data_d           = BYTE_ACK;
            out_commit_d        = 1'b1;
            out_tog_d[ep_idx_s] = ~out_tog_q[ep_idx_s];
          end
        end
      end
      S_SEND_HS: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
        end else if (byte_done_s) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_SEND_HS;
        end
      end
      S_SEND_PID: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = in_tog_q[ep_idx_s] ? BYTE_DATA1 : BYTE_DATA0;
        end else if (byte_done_s) begin
          state_d = (len_q == 7'd0) ? S_SEND_CRC : S_SEND_DATA;
        end else begin
          state_d = S_SEND_PID;
        end
      end
      S_SEND_DATA: begin
        if (byte_done_s) begin
          cnt_d = cnt_q + 7'd1;
          if ((cnt_q + 7'd1) == len_q) begin
            state_d = S_SEND_CRC;
          end else begin
            state_d = S_SEND_DATA;
          end
        end else begin
          state_d = S_SEND_DATA;
        end
      end
      S_SEND_CRC: begin
        if (byte_done_s) begin
          if (crc_hi_q) begin
            crc_hi_d   = 1'b0;
            tx_valid_d = 1'b0;
            state_d    = S_WAIT_HS;
          end else begin
            crc_hi_d = 1'b1;
          end
        end else begin
          state_d = S_SEND_CRC;
        end
      end
      S_WAIT_HS: begin
        if (pid_valid_i) begin
          if (pid_i == PID_ACK) begin
            in_done_d          = 1'b1;
            in_tog_d[ep_idx_s] = ~in_tog_q[ep_idx_s];
          end else begin
            in_done_d = 1'b0;
          end
          state_d = S_IDLE;
        end else if (tmr_q == T_LAST) begin
          state_d = S_IDLE;
        end else if (rx_active_i) begin
          tmr_d = tmr_q;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      tok_pid_q    <= 4'h0;
      ep_q         <= 4'h0;
      len_q        <= 7'd0;
      cnt_q        <= 7'd0;
      tmr_q        <= {TW{1'b0}};
      data1_q      <= 1'b0;
      crc_hi_q     <= 1'b0;
      out_tog_q    <= {NUM_EP{1'b0}};
      in_tog_q     <= {NUM_EP{1'b0}};
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      out_commit_q <= 1'b0;
      out_setup_q  <= 1'b0;
      in_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tok_pid_q    <= tok_pid_d;
      ep_q         <= ep_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      data1_q      <= data1_d;
      crc_hi_q     <= crc_hi_d;
      out_tog_q    <= out_tog_d;
      in_tog_q     <= in_tog_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      out_commit_q <= out_commit_d;
      out_setup_q  <= out_setup_d;
      in_done_q    <= in_done_d;
    end
  end

  // Payload bytes stream straight from the endpoint buffer, CRC bytes from the generator.
  always_comb begin
    case (state_q)
      S_SEND_DATA: tx_data_o = in_data_i;
      S_SEND_CRC:  tx_data_o = crc_hi_q ? crc_s[15:8] : crc_s[7:0];
      default:     tx_data_o = tx_data_q;
    endcase
  end

  assign tx_valid_o   = tx_valid_q;
  assign out_commit_o = out_commit_q;
  assign out_setup_o  = out_setup_q;
  assign in_done_o    = in_done_q;
  assign in_rd_o      = in_rd_s;
  assign xfer_ep_o    = ep_q;

endmodule

// File: tb/tb_usb_transaction_sequencer.sv
// Directed bench for usb_transaction_sequencer (NUM_EP=2, MAX_PKT=8, TIMEOUT=40).
module tb_usb_transaction_sequencer;

  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_SETUP = 4'b1101;
  localparam logic [3:0] P_DATA0 = 4'b0011, P_DATA1 = 4'b1011, P_ACK = 4'b0010;
  localparam logic [6:0] ADDR = 7'h05;

  logic       clk_i = 1'b0;
  logic       reset_i, pid_valid_i, token_valid_i, rx_active_i, crc16_ok_i, tx_ready_i;
  logic [6:0] dev_addr_i, address_i, in_len_i;
  logic [3:0] pid_i, end_point_i, xfer_ep_o;
  logic [7:0] tx_data_o, in_data_i;
  logic       tx_valid_o, out_commit_o, out_setup_o, in_rd_o, in_done_o;
  logic [1:0] ep_stall_i, out_ready_i, in_avail_i;

  int total = 0, bad = 0;
  logic [7:0] got [16];
  logic [7:0] buf_mem [16];
  int got_n, n_rd, rise, n_commit, n_setup, commit_at, ptr, cnt;

  always #5 clk_i = ~clk_i;

  usb_transaction_sequencer #(.NUM_EP(2), .MAX_PKT(8), .TIMEOUT(40)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .dev_addr_i(dev_addr_i), .pid_i(pid_i),
    .pid_valid_i(pid_valid_i), .address_i(address_i), .end_point_i(end_point_i),
    .token_valid_i(token_valid_i), .rx_active_i(rx_active_i), .crc16_ok_i(crc16_ok_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .ep_stall_i(ep_stall_i), .out_ready_i(out_ready_i), .out_commit_o(out_commit_o),
    .out_setup_o(out_setup_o), .in_avail_i(in_avail_i), .in_len_i(in_len_i),
    .in_data_i(in_data_i), .in_rd_o(in_rd_o), .in_done_o(in_done_o), .xfer_ep_o(xfer_ep_o)
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    pid_i = p; pid_valid_i = 1'b1; cyc(); pid_valid_i = 1'b0;
    address_i = a; end_point_i = e; token_valid_i = 1'b1; cyc(); token_valid_i = 1'b0;
  endtask

  task automatic send_data(input logic [3:0] p, input logic ok);
    pid_i = p; pid_valid_i = 1'b1; rx_active_i = 1'b1; cyc(); pid_valid_i = 1'b0;
    cyc(); cyc(); rx_active_i = 1'b0; crc16_ok_i = ok;
  endtask

  task automatic host_pid(input logic [3:0] p);
    pid_i = p; pid_valid_i = 1'b1; cyc(); pid_valid_i = 1'b0;
  endtask

  task automatic load_buf();
    for (int i = 0; i < 16; i++) buf_mem[i] = 8'(i + 1);
    ptr = 0; in_data_i = buf_mem[0];
  endtask

  // Records accepted bytes until tx_valid falls or the budget runs out.
  task automatic collect(input int budget);
    logic seen, prev_rd;
    seen = 1'b0; prev_rd = 1'b0;
    got_n = 0; n_rd = 0; rise = 0; n_commit = 0; n_setup = 0; commit_at = 0;
    for (int c = 1; c <= budget; c++) begin
      cyc();
      if (prev_rd) begin
        if (ptr < 15) ptr++;
        in_data_i = buf_mem[ptr];
      end
      #1;
      if (tx_valid_o) begin
        if (!seen) begin seen = 1'b1; rise = c; end
        if (tx_ready_i) begin
          if (got_n < 16) got[got_n] = tx_data_o;
          got_n++;
        end
      end else if (seen) begin
        break;
      end
      if (out_commit_o) begin n_commit++; commit_at = c; end
      if (out_setup_o) n_setup++;
      if (in_rd_o) n_rd++;
      prev_rd = in_rd_o;
    end
  endtask

  initial begin
    reset_i = 1'b1; pid_valid_i = 1'b0; token_valid_i = 1'b0; rx_active_i = 1'b0;
    crc16_ok_i = 1'b1; tx_ready_i = 1'b1; dev_addr_i = ADDR; address_i = 7'h00;
    pid_i = 4'h0; end_point_i = 4'h0; in_len_i = 7'd0; in_data_i = 8'h00;
    ep_stall_i = 2'b00; out_ready_i = 2'b11; in_avail_i = 2'b11;
    load_buf();
    cyc(); cyc(); cyc();
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_tx_data", tx_data_o, 8'h00);
    check("rst_xfer_ep", xfer_ep_o, 4'h0);
    check("rst_pulses", {out_commit_o, out_setup_o, in_rd_o, in_done_o}, 4'b0000);
    reset_i = 1'b0; cyc();

    // ZLP IN on ep1, toggle 0, then host ACK
    send_token(P_IN, ADDR, 4'd1);
    collect(30);
    check("zlp_rise", rise, 1);
    check("zlp_len", got_n, 3);
    check("zlp_b0", got[0], 8'hC3);
    check("zlp_crc", {got[1], got[2]}, 16'h0000);
    check("zlp_rd", n_rd, 0);
    check("zlp_xfer_ep", xfer_ep_o, 4'd1);
    host_pid(P_ACK);
    check("zlp_done", in_done_o, 1'b1);
    cyc();
    check("zlp_done_end", in_done_o, 1'b0);
    send_token(P_IN, ADDR, 4'd1);
    collect(30);
    check("zlp2_pid", got[0], 8'h4B);
    host_pid(P_ACK); cyc();

    // 3-byte IN, CRC16 of 01 02 03 is 9E9E, host never ACKs
    in_len_i = 7'd3; load_buf();
    send_token(P_IN, ADDR, 4'd1);
    collect(30);
    check("in3_len", got_n, 6);
    check("in3_pid", got[0], 8'hC3);
    check("in3_data", {got[1], got[2], got[3]}, 24'h010203);
    check("in3_crc", {got[4], got[5]}, 16'h9E9E);
    check("in3_rd", n_rd, 3);
    cnt = 0;
    for (int i = 0; i < 45; i++) begin cyc(); if (in_done_o) cnt++; end
    check("in3_no_done", cnt, 0);
    in_len_i = 7'd0;
    send_token(P_IN, ADDR, 4'd1);
    collect(30);
    check("in3_resend_pid", got[0], 8'hC3);
    host_pid(P_ACK); cyc();

    // in_len above MAX_PKT is clamped to 8
    in_len_i = 7'd10; load_buf();
    send_token(P_IN, ADDR, 4'd0);
    collect(40);
    check("clamp_rd", n_rd, 8);
    check("clamp_len", got_n, 11);
    check("clamp_last", got[8], 8'h08);
    host_pid(P_ACK); cyc();
    in_len_i = 7'd0;

    // SETUP ep0 ACKs, commits, and forces IN toggle to DATA1
    send_token(P_SETUP, ADDR, 4'd0);
    send_data(P_DATA0, 1'b1);
    collect(10);
    check("setup_rise", rise, 1);
    check("setup_hs", {got_n[7:0], got[0]}, {8'd1, 8'hD2});
    check("setup_commit", {n_commit[7:0], n_setup[7:0]}, 16'h0101);
    check("setup_commit_at", commit_at, 1);
    send_token(P_IN, ADDR, 4'd0);
    collect(30);
    check("setup_in_pid", got[0], 8'h4B);
    host_pid(P_ACK); cyc();

    // OUT ep1: new data, retransmission, NAK, STALL
    send_token(P_OUT, ADDR, 4'd1);
    end_point_i = 4'd0; token_valid_i = 1'b1; cyc(); token_valid_i = 1'b0;
    check("busy_token_ignored", xfer_ep_o, 4'd1);
    send_data(P_DATA0, 1'b1);
    collect(10);
    check("out_ack", got[0], 8'hD2);
    check("out_commit", {n_commit[7:0], n_setup[7:0]}, 16'h0100);
    check("out_commit_at", commit_at, rise);
    send_token(P_OUT, ADDR, 4'd1);
    send_data(P_DATA0, 1'b1);
    collect(10);
    check("retx_ack", got[0], 8'hD2);
    check("retx_no_commit", n_commit, 0);
    out_ready_i = 2'b01;
    send_token(P_OUT, ADDR, 4'd1);
    send_data(P_DATA1, 1'b1);
    collect(10);
    check("out_nak", {got_n[7:0], got[0], n_commit[7:0]}, {8'd1, 8'h5A, 8'd0});
    out_ready_i = 2'b11; ep_stall_i = 2'b10;
    send_token(P_OUT, ADDR, 4'd1);
    send_data(P_DATA1, 1'b1);
    collect(10);
    check("out_stall", {got_n[7:0], got[0], n_commit[7:0]}, {8'd1, 8'h1E, 8'd0});
    send_token(P_IN, ADDR, 4'd1);
    collect(10);
    check("in_stall", {rise[7:0], got[0]}, {8'd1, 8'h1E});
    ep_stall_i = 2'b00; in_avail_i = 2'b01;
    send_token(P_IN, ADDR, 4'd1);
    collect(10);
    check("in_nak", {rise[7:0], got[0]}, {8'd1, 8'h5A});
    in_avail_i = 2'b11;

    // Silent cases: bad CRC, wrong address, endpoint out of range
    send_token(P_OUT, ADDR, 4'd1);
    send_data(P_DATA1, 1'b0);
    collect(10);
    check("badcrc_silent", {rise[7:0], n_commit[7:0]}, 16'h0000);
    crc16_ok_i = 1'b1;
    send_token(P_OUT, 7'h06, 4'd1);
    send_data(P_DATA1, 1'b1);
    collect(10);
    check("badaddr_silent", {rise[7:0], n_commit[7:0]}, 16'h0000);
    send_token(P_OUT, ADDR, 4'd2);
    send_data(P_DATA1, 1'b1);
    collect(10);
    check("badep_silent", {rise[7:0], n_commit[7:0]}, 16'h0000);
    check("badep_xfer_ep", xfer_ep_o, 4'd1);
    send_token(P_OUT, ADDR, 4'd1);
    send_data(P_DATA1, 1'b1);
    collect(10);
    check("out_data1_commit", n_commit, 1);
    send_token(P_OUT, ADDR, 4'd1);
    send_data(P_DATA0, 1'b1);
    collect(10);
    check("out_data0_commit", n_commit, 1);

    // Reset in the middle of the payload
    in_len_i = 7'd3; load_buf();
    send_token(P_IN, ADDR, 4'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      if (in_rd_o) begin cnt = 1; break; end
    end
    check("rst_mid_reached", cnt, 1);
    reset_i = 1'b1; cyc();
    check("rst_mid_tx_valid", tx_valid_o, 1'b0);
    check("rst_mid_no_done", in_done_o, 1'b0);
    reset_i = 1'b0; cyc();
    in_len_i = 7'd0;
    send_token(P_IN, ADDR, 4'd1);
    collect(30);
    check("rst_in_tog", got[0], 8'hC3);
    host_pid(P_ACK); cyc();
    send_token(P_OUT, ADDR, 4'd1);
    send_data(P_DATA1, 1'b1);
    collect(10);
    check("rst_out_tog", {got[0], n_commit[7:0]}, {8'hD2, 8'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_transaction_sequencer.md
# usb_transaction_sequencer

Sequences USB full-speed transactions on top of `usb_controller` and the SIE.
- Consumes decoded PID, token and data events, and checks device address and endpoint.
- Tracks the DATA0/DATA1 toggle per endpoint.
- Drives the SIE TX byte stream: handshakes (ACK/NAK/STALL) and IN data packets with a generated CRC16.
- Presents a simple commit/read interface to the endpoint buffers.

## Interface
Parameters:
- NUM_EP, 2, number of endpoints implemented (1..16).
- MAX_PKT, 8, maximum IN payload in bytes (≤64).
- TIMEOUT, 40, clk cycles to wait for a host DATA or ACK packet before abandoning the transaction.

Ports:
- clk  in  1  system clock (24 MHz)
- reset  in  1  synchronous, active-high reset
- dev_addr  in  7  configured device address
- pid  in  pid_t  PID from usb_controller
- pid_valid  in  1  PID strobe
- address  in  7  token address
- end_point  in  4  token endpoint
- token_valid  in  1  token received with good CRC5
- rx_active  in  1  SIE receive active
- crc16_ok  in  1  data CRC16 good; sampled on the cycle rx_active is first seen low
- tx_data  out  8  byte to SIE
- tx_valid  out  1  rise: SYNC; high: send; fall: EOP
- tx_ready  in  1  byte on tx_data accepted this cycle
- ep_stall  in  NUM_EP  per-endpoint stall
- out_ready  in  NUM_EP  endpoint can accept an OUT/SETUP payload
- out_commit  out  1  pulse: received payload accepted (new data)
- out_setup  out  1  qualifies out_commit as SETUP
- in_avail  in  NUM_EP  endpoint has an IN packet
- in_len  in  7  IN payload length, sampled at the IN token
- in_data  in  8  current IN byte
- in_rd  out  1  pulse: in_data consumed, advance
- in_done  out  1  pulse: host ACKed IN packet
- xfer_ep  out  4  endpoint of the current transaction

## Operation
- Token handling:
  - A token is accepted only if token_valid is high, address==dev_addr and end_point<NUM_EP.
  - Otherwise it is ignored and the block stays in IDLE.
- States: IDLE, WAIT_DATA, RX_DATA, SEND_HS, SEND_PID, SEND_DATA, SEND_CRC, WAIT_HS.
- IDLE:
  - Accepted OUT/SETUP → WAIT_DATA.
  - Accepted IN:
    - ep_stall → SEND_HS(STALL).
    - !in_avail → SEND_HS(NAK).
    - else → SEND_PID.
- WAIT_DATA:
  - pid_valid with DATA0/DATA1 → RX_DATA, latching the data PID.
  - Any other pid_valid → IDLE.
  - TIMEOUT expiry → IDLE.
- RX_DATA (decision taken when rx_active is seen low):
  - !crc16_ok → IDLE, no response.
  - SETUP: always ACK. out_commit=out_setup=1. OUT and IN toggles of the endpoint set to 1. ep_stall is ignored.
  - OUT with ep_stall → STALL.
  - OUT with !out_ready → NAK.
  - OUT whose data PID ≠ expected toggle → ACK, no commit (retransmission).
  - Otherwise → ACK, out_commit, OUT toggle flips.
- SEND_HS:
  - Single byte {~pid,pid]: ACK 8'hD2, NAK 8'h5A, STALL 8'h1E.
  - → IDLE when accepted.
- IN data path:
  - SEND_PID: sends DATA0 8'hC3 or DATA1 8'h4B per the IN toggle.
  - SEND_DATA: in_len bytes; in_rd pulses on each accepted byte.
  - SEND_CRC: two bytes, low byte first, then → WAIT_HS.
- CRC16:
  - Polynomial x^16+x^15+x^2+1, reflected, init 16'hFFFF.
  - Transmitted value is the complemented remainder.
  - Zero-length packet sends 8'h00, 8'h00.
- WAIT_HS:
  - pid_valid ACK → in_done pulse, IN toggle flips, → IDLE.
  - Other PID or TIMEOUT → IDLE, toggle unchanged.
- xfer_ep holds the endpoint of the last accepted token.
- in_len > MAX_PKT is clamped to MAX_PKT.

## Timing
- Reset: state IDLE; all toggles 0; tx_valid, in_rd, out_commit, out_setup, in_done 0; tx_data 8'h00; xfer_ep 0.
- Reset mid-transmission drops tx_valid on the next edge (SIE sees EOP). No done or commit pulse is issued.
- tx_valid timing:
  - IN token: tx_valid rises 2 cycles after the token_valid cycle.
  - OUT/SETUP: tx_valid rises 1 cycle after rx_active is sampled low.
- Byte handshake:
  - A byte completes on tx_valid&&tx_ready.
  - The next byte is on tx_data the following cycle.
  - tx_valid stays high between bytes.
  - tx_valid falls the cycle after the last byte completes.
- Pulse alignment:
  - in_rd is coincident with the completing cycle of each payload byte.
  - out_commit/out_setup pulse in the same cycle tx_valid rises for the ACK.
  - in_done pulses one cycle after pid_valid(ACK).
- TIMEOUT counter:
  - Starts on entry to WAIT_DATA/WAIT_HS.
  - Is held while rx_active is high.
  - Saturates; expiry at count TIMEOUT-1.
- token_valid arriving while not in IDLE is ignored.

## Structure
- `types` package: existing pid_t (OUT 4'b0001, IN 4'b1001, SETUP 4'b1101, DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010, STALL 4'b1110), plus PID-byte constants and CRC16 polynomial/init constants.
- Sub-module usb_crc16_gen, used for the IN payload CRC. Ports: clk, reset, clear, data_valid, data[7:0], crc[15:0] (complemented, reflected).

## Test plan
- IN ep1, in_avail=1, in_len=0, toggle 0 → bytes C3,00,00; host ACK → in_done, next IN sends 4B.
- IN ep1, in_len=3 data 01,02,03 → C3,01,02,03,crc; 3 in_rd pulses; no ACK within TIMEOUT → IDLE, next IN resends C3.
- SETUP ep0, DATA0, crc16_ok → D2, out_commit+out_setup; following IN ep0 sends DATA1 (4B).
- OUT ep1: DATA0 ok → D2+commit; repeat DATA0 → D2 no commit; out_ready=0 → 5A; ep_stall → 1E.
- OUT with crc16_ok=0, wrong dev_addr, or end_point=NUM_EP → no tx_valid, no commit.
- Assert reset during SEND_DATA → tx_valid low next cycle, toggles 0, no in_done.
